// File: rtl/clock_reg_pkg.sv
// Shared types and sizing helpers for the clock-domain register write scheduler.
package clock_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int MAX_HOLDOFF = 15;
    localparam int HOLD_W      = $clog2(MAX_HOLDOFF + 1);

    // Index width for n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_reg_rr_arbiter.sv
// Combinational round-robin picker: searches from last_i+1 with wrap-around.
module clock_reg_rr_arbiter
    import clock_reg_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int REQ_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [REQ_W-1:0]   last_i,
    output logic [REQ_W-1:0]   grant_o,
    output logic               any_o
);

    int               idx;
    logic [REQ_W-1:0] idx_r;

    // Walk candidates farthest-first so the nearest one after last_i wins.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        idx     = 0;
        idx_r   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(last_i) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_r = REQ_W'(idx);
            if (req_i[idx_r]) begin
                grant_o = idx_r;
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_reg_write_scheduler.sv
// Arbitrates register writes into the cross-domain latch bank, one trigger per
// grant, with a forced idle gap so each value survives the read-side synchroniser.
module clock_reg_write_scheduler
    import clock_reg_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int NUM_REGS  = 8,
    parameter  int DATA_SIZE = 32,
    parameter  int HOLDOFF   = 4,
    localparam int ADDR_W    = idx_w(NUM_REGS),
    localparam int REQ_W     = idx_w(NUM_REQ)
) (
    input  logic                          write_clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_SIZE-1:0]  req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REGS-1:0]           write_trigger,
    output logic [DATA_SIZE-1:0]          write_data_out,
    output logic                          addr_err,
    output logic                          busy
);

    logic [NUM_REQ-1:0][ADDR_W-1:0]    addr_a;
    logic [NUM_REQ-1:0][DATA_SIZE-1:0] data_a;

    assign addr_a = req_addr;
    assign data_a = req_data;

    state_t                 state_q;
    logic [HOLD_W-1:0]      cnt_q;
    logic [REQ_W-1:0]       rr_q;
    logic [NUM_REQ-1:0]     ack_q;
    logic [NUM_REGS-1:0]    trig_q;
    logic [DATA_SIZE-1:0]   data_q;
    logic                   err_q;

    logic [REQ_W-1:0]       grant;
    logic                   any_req;
    logic [ADDR_W-1:0]      addr_sel;
    logic                   oob_d;
    logic [NUM_REGS-1:0]    trig_d;
    logic [NUM_REQ-1:0]     ack_d;

    clock_reg_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (req_valid),
        .last_i  (rr_q),
        .grant_o (grant),
        .any_o   (any_req)
    );

    // Out-of-range addresses still get acked (no deadlock) but trigger nothing.
    always_comb begin
        addr_sel = addr_a[grant];
        oob_d    = 32'(addr_sel) >= 32'(NUM_REGS);
        trig_d   = oob_d ? '0 : (NUM_REGS'(1) << addr_sel);
        ack_d    = NUM_REQ'(1) << grant;
    end

    always_ff @(posedge write_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= REQ_W'(NUM_REQ - 1);
            ack_q   <= '0;
            trig_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        data_q  <= data_a[grant];
                        trig_q  <= trig_d;
                        ack_q   <= ack_d;
                        err_q   <= oob_d;
                        rr_q    <= grant;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    trig_q  <= '0;
                    ack_q   <= '0;
                    err_q   <= 1'b0;
                    cnt_q   <= HOLD_W'(HOLDOFF - 1);
                    state_q <= HOLD;
                end
                // Requests are deliberately not sampled here, so a requester
                // dropping valid the cycle after ack is never granted twice.
                HOLD: begin
                    if (cnt_q == '0) state_q <= IDLE;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ack        = ack_q;
    assign write_trigger  = trig_q;
    assign write_data_out = data_q;
    assign addr_err       = err_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_clock_reg_write_scheduler.sv
// Scoreboard bench: stimulus pushes expected grants, a negedge monitor pops and checks them.
module tb_clock_reg_write_scheduler;

    localparam int NREQ = 4;
    localparam int NREG = 6;
    localparam int DW   = 32;
    localparam int HO   = 4;
    localparam int AW   = 3;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [NREQ-1:0]          req_valid = '0;
    logic [NREQ-1:0][AW-1:0]  addr_a = '0;
    logic [NREQ-1:0][DW-1:0]  data_a = '0;
    logic [NREQ-1:0]          req_ack;
    logic [NREG-1:0]          write_trigger;
    logic [DW-1:0]            write_data_out;
    logic                     addr_err;
    logic                     busy;

    clock_reg_write_scheduler #(
        .NUM_REQ   (NREQ),
        .NUM_REGS  (NREG),
        .DATA_SIZE (DW),
        .HOLDOFF   (HO)
    ) dut (
        .write_clk      (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_addr       (addr_a),
        .req_data       (data_a),
        .req_ack        (req_ack),
        .write_trigger  (write_trigger),
        .write_data_out (write_data_out),
        .addr_err       (addr_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          req;
        logic        err;
        logic [5:0]  trig;
        logic [31:0] data;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   ack_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int r, input logic e, input logic [5:0] t,
                        input logic [31:0] d, input int g);
        exp_t x;
        x.req = r; x.err = e; x.trig = t; x.data = d; x.gap = g;
        sb.push_back(x);
    endtask

    // Monitor: every ack must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (req_ack != '0) begin
                ack_seen++;
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 64'(req_ack), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_onehot", 64'(req_ack), 64'(4'b0001 << e.req));
                    chk("trigger",    64'(write_trigger), 64'(e.trig));
                    chk("addr_err",   64'(addr_err), 64'(e.err));
                    chk("data",       64'(write_data_out), 64'(e.data));
                    if (e.gap >= 0) chk("trigger_gap", 64'(cyc - last_cyc), 64'(e.gap));
                end
                last_cyc = cyc;
            end else if (write_trigger != '0 || addr_err) begin
                chk("spurious_trigger", 64'({addr_err, write_trigger}), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sb(input int n, input int budget);
        int b = 0;
        while (sb.size() > n && b < budget) begin
            tick();
            b++;
        end
        if (sb.size() > n) begin
            chk("timeout_waiting_ack", 64'(sb.size()), 64'(n));
            sb.delete();
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks0;
        // Reset state
        tick();
        chk("rst_trigger", 64'(write_trigger), 64'd0);
        chk("rst_ack",     64'(req_ack), 64'd0);
        chk("rst_data",    64'(write_data_out), 64'd0);
        chk("rst_busy",    64'(busy), 64'd0);
        chk("rst_err",     64'(addr_err), 64'd0);
        reset_n = 1'b1;
        tick();

        // Single request: req 2, addr 5, data DEADBEEF
        addr_a[2] = 3'd5; data_a[2] = 32'hDEAD_BEEF;
        push(2, 1'b0, 6'h20, 32'hDEAD_BEEF, -1);
        req_valid = 4'b0100;
        tick();
        chk("single_busy_issue", 64'(busy), 64'd1);
        tick();
        req_valid = '0;
        repeat (3) tick();
        chk("single_busy_hold_end", 64'(busy), 64'd1);
        tick();
        chk("single_busy_idle", 64'(busy), 64'd0);
        wait_sb(0, 2);

        // Contention: all four valid after reset -> 0,1,2,3,0, 6 cycles apart
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i] = AW'(i);
            data_a[i] = 32'h1111_1111 * (i + 1);
        end
        push(0, 1'b0, 6'h01, 32'h1111_1111, -1);
        push(1, 1'b0, 6'h02, 32'h2222_2222, HO + 2);
        push(2, 1'b0, 6'h04, 32'h3333_3333, HO + 2);
        push(3, 1'b0, 6'h08, 32'h4444_4444, HO + 2);
        push(0, 1'b0, 6'h01, 32'h1111_1111, HO + 2);
        req_valid = 4'b1111;
        wait_sb(0, 60);
        req_valid = '0;

        // Out of range: req 0, addr 7 -> acked, addr_err, no trigger
        addr_a[0] = 3'd7; data_a[0] = 32'h0BAD_F00D;
        push(0, 1'b1, 6'h00, 32'h0BAD_F00D, -1);
        req_valid = 4'b0001;
        wait_sb(0, 20);
        req_valid = '0;
        repeat (8) tick();
        chk("data_holds_idle", 64'(write_data_out), 64'h0BAD_F00D);

        // Withdrawal: req 1 asserted during HOLD, dropped before IDLE
        addr_a[2] = 3'd1; data_a[2] = 32'h0000_0022;
        push(2, 1'b0, 6'h02, 32'h0000_0022, -1);
        req_valid = 4'b0100;
        wait_sb(0, 20);
        acks0 = ack_seen;
        addr_a[1] = 3'd4; data_a[1] = 32'h0000_0011;
        req_valid = 4'b0010;
        tick();
        tick();
        req_valid = '0;
        repeat (10) tick();
        chk("withdraw_no_ack", 64'(ack_seen), 64'(acks0));

        // Reset mid-ISSUE
        addr_a[1] = 3'd3; data_a[1] = 32'h0000_0055;
        req_valid = 4'b0010;
        tick();
        chk("pre_reset_ack", 64'(req_ack), 64'b0010);
        chk("pre_reset_trig", 64'(write_trigger), 64'h08);
        reset_n = 1'b0;
        #1;
        chk("midrst_trigger", 64'(write_trigger), 64'd0);
        chk("midrst_ack",     64'(req_ack), 64'd0);
        chk("midrst_data",    64'(write_data_out), 64'd0);
        chk("midrst_busy",    64'(busy), 64'd0);
        req_valid = '0;
        tick();
        reset_n = 1'b1;
        addr_a[0] = 3'd2; data_a[0] = 32'h0000_00A0;
        push(0, 1'b0, 6'h04, 32'h0000_00A0, -1);
        req_valid = 4'b1011;
        wait_sb(0, 20);
        req_valid = '0;
        repeat (8) tick();

        // Back-to-back single requester: data 1,2,3 every HOLDOFF+2 cycles
        addr_a[3] = 3'd4;
        push(3, 1'b0, 6'h10, 32'd1, -1);
        push(3, 1'b0, 6'h10, 32'd2, HO + 2);
        push(3, 1'b0, 6'h10, 32'd3, HO + 2);
        for (int d = 1; d <= 3; d++) begin
            data_a[3] = 32'(d);
            req_valid = 4'b1000;
            wait_sb(3 - d, 20);
        end
        req_valid = '0;
        repeat (10) tick();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
